// File: rtl/frame_writer.sv
// Pixel-stream to Wishbone frame writer: buffers sync'd pixel words in a small
// FWFT FIFO and writes each one to its linear frame-buffer byte address.
module frame_writer #(
  parameter int HDISP            = 800,
  parameter int VDISP            = 480,
  parameter int FIFO_DEPTH_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [31:0] pix_data,
  input  logic        pix_sof,
  input  logic        enable,
  output logic        wshb_cyc,
  output logic        wshb_stb,
  output logic        wshb_we,
  output logic [31:0] wshb_adr,
  output logic [3:0]  wshb_sel,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  output logic [31:0] wshb_dat_ms,
  input  logic        wshb_ack,
  output logic        frame_done,
  output logic        sof_err
);

  localparam int DEPTH = 1 << FIFO_DEPTH_WIDTH;
  localparam int XW    = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW    = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam logic [FIFO_DEPTH_WIDTH:0] FULL_CNT = (FIFO_DEPTH_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK} state_t;

  state_t state_q, state_d;

  logic [32:0]                 mem_q [DEPTH];
  logic [FIFO_DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_WIDTH:0]   count_q, count_d;
  logic                        ready_en_q, ready_en_d;
  logic                        synced_q, synced_d;
  logic [XW-1:0]               x_q, x_d;
  logic [YW-1:0]               y_q, y_d;
  logic [31:0]                 adr_q, adr_d, dat_q, dat_d;
  logic                        frame_done_q, frame_done_d;

  logic        fifo_empty, fifo_full, accept, push, pop;
  logic [32:0] head;
  logic [XW-1:0] lat_x;
  logic [YW-1:0] lat_y;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign pix_ready  = ready_en_q && !fifo_full;
  assign accept     = pix_valid && pix_ready;
  // Until the first SOF is seen, accepted words are swallowed rather than stored.
  assign push       = accept && (synced_q || pix_sof);
  assign pop        = (state_q == REQ);
  assign head       = mem_q[rd_ptr_q];

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: a default assignment first keeps every path assigned, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (!fifo_empty && enable) state_d = REQ;
      REQ:      state_d = WAIT_ACK;
      WAIT_ACK: if (wshb_ack) state_d = (!fifo_empty && enable) ? REQ : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    wshb_cyc = (state_q == WAIT_ACK);
    wshb_stb = (state_q == WAIT_ACK);
    sof_err  = (state_q == REQ) && head[32] && ((x_q != '0) || (y_q != '0));
  end

  assign wshb_we     = 1'b1;
  assign wshb_sel    = 4'b1111;
  assign wshb_cti    = 3'b000;
  assign wshb_bte    = 2'b00;
  assign wshb_adr    = adr_q;
  assign wshb_dat_ms = dat_q;
  assign frame_done  = frame_done_q;

  // ---------------- FIFO and address datapath ----------------
  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d      = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ready_en_d   = 1'b1;
    synced_d     = synced_q || (accept && pix_sof);
    x_d          = x_q;
    y_d          = y_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    frame_done_d = 1'b0;
    lat_x        = head[32] ? '0 : x_q;
    lat_y        = head[32] ? '0 : y_q;

    if (state_q == REQ) begin
      adr_d = (32'(lat_x) + 32'(lat_y) * 32'(HDISP)) << 2;
      dat_d = head[31:0];
      x_d   = lat_x;
      y_d   = lat_y;
    end else if (state_q == WAIT_ACK && wshb_ack) begin
      if (x_q == XW'(HDISP-1)) begin
        x_d = '0;
        if (y_q == YW'(VDISP-1)) begin
          y_d          = '0;
          frame_done_d = 1'b1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // NOTE: FIFO storage is not reset; emptiness is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {pix_sof, pix_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ready_en_q   <= 1'b0;
      synced_q     <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ready_en_q   <= ready_en_d;
      synced_q     <= synced_d;
      x_q          <= x_d;
      y_q          <= y_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer on a 4x2 frame: a frame-position model
// predicts every Wishbone write; directed scenarios pin the model with literals.
module tb_frame_writer;

  localparam int H = 4;
  localparam int V = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [31:0] pix_data = '0;
  logic        pix_sof = 1'b0;
  logic        enable = 1'b0;
  logic        wshb_cyc, wshb_stb, wshb_we;
  logic [31:0] wshb_adr, wshb_dat_ms;
  logic [3:0]  wshb_sel;
  logic [2:0]  wshb_cti;
  logic [1:0]  wshb_bte;
  logic        wshb_ack;
  logic        frame_done, sof_err;

  always #5 clk = ~clk;

  frame_writer #(.HDISP(H), .VDISP(V), .FIFO_DEPTH_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_sof(pix_sof),
    .enable(enable),
    .wshb_cyc(wshb_cyc), .wshb_stb(wshb_stb), .wshb_we(wshb_we), .wshb_adr(wshb_adr),
    .wshb_sel(wshb_sel), .wshb_cti(wshb_cti), .wshb_bte(wshb_bte),
    .wshb_dat_ms(wshb_dat_ms), .wshb_ack(wshb_ack),
    .frame_done(frame_done), .sof_err(sof_err)
  );

  // Slave: acks after ack_delay cycles of stb, unless blocked.
  int wait_cnt = 0;
  int ack_delay = 0;
  bit ack_block = 1'b0;
  assign wshb_ack = wshb_stb && !ack_block && (wait_cnt >= ack_delay);
  always @(posedge clk) wait_cnt <= (wshb_stb === 1'b1 && wshb_ack !== 1'b1) ? wait_cnt + 1 : 0;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    bit          err;
    bit          last;
  } wr_t;

  wr_t exp_q[$];
  bit  m_synced;
  int  m_pos;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, n_obs = 0, n_fd = 0, n_err = 0, n_ack = 0, n_stb_cyc = 0;
  logic [31:0] obs_adr [256];
  logic [31:0] obs_dat [256];
  int          obs_cyc [256];
  bit          fd_next, prev_stb, prev_ack, prev_err;
  logic [31:0] prev_adr, prev_dat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-position model: each stored word lands at the next linear pixel slot.
  task automatic model_push(input bit sof, input logic [31:0] d);
    wr_t e;
    if (!m_synced && !sof) return;
    m_synced = 1'b1;
    e.err = sof && (m_pos != 0);
    if (sof) m_pos = 0;
    e.adr  = 32'(m_pos * 4);
    e.dat  = d;
    e.last = (m_pos == H*V - 1);
    m_pos  = (m_pos + 1) % (H*V);
    exp_q.push_back(e);
  endtask

  // One clock: sample inputs for the coming edge, then compare outputs on the falling edge.
  task automatic tick();
    bit acc, rst_now, rise;
    logic sof_in;
    logic [31:0] dat_in;
    wr_t e;
    acc     = (pix_valid && pix_ready) === 1'b1;
    sof_in  = pix_sof;
    dat_in  = pix_data;
    rst_now = rst_n;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (!rst_now) begin
      exp_q.delete();
      m_synced = 1'b0; m_pos = 0;
      fd_next = 1'b0; prev_stb = 1'b0; prev_ack = 1'b0; prev_err = 1'b0;
      return;
    end
    rise = wshb_stb && !prev_stb;
    check("frame_done", frame_done, fd_next);
    fd_next = 1'b0;
    check("cyc_eq_stb", wshb_cyc, wshb_stb);
    if (frame_done) n_fd++;
    if (sof_err) n_err++;
    if (rise) begin
      check("write_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("sof_err_at_req", prev_err, exp_q[0].err);
    end else begin
      check("sof_err_quiet", prev_err, 0);
    end
    if (wshb_stb) begin
      n_stb_cyc++;
      check("we", wshb_we, 1);
      check("sel", wshb_sel, 4'hF);
      check("cti", wshb_cti, 0);
      check("bte", wshb_bte, 0);
      if (!rise && !prev_ack) begin
        check("adr_stable", wshb_adr, prev_adr);
        check("dat_stable", wshb_dat_ms, prev_dat);
      end
      if (wshb_ack && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("adr", wshb_adr, e.adr);
        check("dat", wshb_dat_ms, e.dat);
        fd_next = e.last;
        if (n_obs < 256) begin
          obs_adr[n_obs] = wshb_adr;
          obs_dat[n_obs] = wshb_dat_ms;
          obs_cyc[n_obs] = cyc;
          n_obs++;
        end
        n_ack++;
      end
    end
    prev_stb = wshb_stb; prev_ack = wshb_ack; prev_err = sof_err;
    prev_adr = wshb_adr; prev_dat = wshb_dat_ms;
    if (acc) model_push(sof_in, dat_in);
  endtask

  task automatic send(input bit sof, input logic [31:0] d);
    bit ok = 1'b0;
    pix_valid = 1'b1; pix_sof = sof; pix_data = d;
    for (int i = 0; i < 300; i++) begin
      ok = (pix_ready === 1'b1);
      tick();
      if (ok) break;
    end
    pix_valid = 1'b0; pix_sof = 1'b0;
    check("send_accepted", 32'(ok), 1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0 && wshb_stb === 1'b0) begin done = 1'b1; break; end
      tick();
    end
    check("drain_done", 32'(done), 1);
    repeat (4) tick();
  endtask

  task automatic do_reset();
    pix_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("rst_cyc", wshb_cyc, 0);
    check("rst_stb", wshb_stb, 0);
    check("rst_adr", wshb_adr, 0);
    check("rst_dat", wshb_dat_ms, 0);
    check("rst_ready", pix_ready, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_sof_err", sof_err, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ready_after_release", pix_ready, 1);
  endtask

  initial begin
    int b, fd0, er0, base, sb;
    bit found;

    do_reset();

    // V1: pre-SOF words dropped, one write to 0x0.
    enable = 1'b1; b = n_obs;
    send(0, 32'h1); send(0, 32'h2); send(0, 32'h3); send(1, 32'hA5);
    drain();
    check("v1_writes", n_obs - b, 1);
    check("v1_adr", obs_adr[b], 32'h0);
    check("v1_dat", obs_dat[b], 32'hA5);

    // V2: preloaded full frame, zero-wait slave.
    do_reset();
    enable = 1'b0; ack_delay = 0; b = n_obs; fd0 = n_fd;
    send(1, 32'h100);
    for (int i = 1; i < 8; i++) send(0, 32'h100 + 32'(i));
    repeat (3) tick();
    enable = 1'b1;
    drain();
    check("v2_writes", n_obs - b, 8);
    for (int i = 0; i < 8; i++) check("v2_adr", obs_adr[b+i], 32'(i*4));
    for (int i = 1; i < 8; i++) check("v2_spacing", obs_cyc[b+i] - obs_cyc[b+i-1], 2);
    check("v2_frame_done_count", n_fd - fd0, 1);

    // V3: 5-cycle ack delay, FIFO fills to 16, then continuous streaming.
    do_reset();
    enable = 1'b0; ack_delay = 5; b = n_obs; fd0 = n_fd;
    send(1, 32'h1000);
    for (int i = 1; i < 16; i++) send(0, 32'h1000 + 32'(i));
    check("v3_ready_low_full", pix_ready, 0);
    enable = 1'b1;
    for (int i = 16; i < 26; i++) send(0, 32'h1000 + 32'(i));
    drain();
    check("v3_writes", n_obs - b, 26);
    for (int i = 0; i < 26; i++) check("v3_dat_order", obs_dat[b+i], 32'h1000 + 32'(i));
    check("v3_adr_wrap", obs_adr[b+9], 32'h4);
    check("v3_frame_done_count", n_fd - fd0, 3);

    // V4: SOF at pixel 5 (line 1, x=1) restarts the frame.
    do_reset();
    ack_delay = 0; b = n_obs; er0 = n_err;
    send(1, 32'h200);
    for (int i = 1; i < 5; i++) send(0, 32'h200 + 32'(i));
    send(1, 32'h205); send(0, 32'h206); send(0, 32'h207);
    drain();
    check("v4_writes", n_obs - b, 8);
    check("v4_sof_err_count", n_err - er0, 1);
    check("v4_adr4", obs_adr[b+4], 32'h10);
    check("v4_adr5", obs_adr[b+5], 32'h0);
    check("v4_dat5", obs_dat[b+5], 32'h205);
    check("v4_adr6", obs_adr[b+6], 32'h4);
    check("v4_adr7", obs_adr[b+7], 32'h8);

    // V5: enable drops during a pending write; it completes, then nothing until re-enabled.
    do_reset();
    ack_delay = 3; b = n_obs; found = 1'b0;
    send(1, 32'h400);
    for (int i = 1; i < 6; i++) send(0, 32'h400 + 32'(i));
    for (int i = 0; i < 500; i++) begin
      if (n_ack - b >= 2 && wshb_stb === 1'b1 && wait_cnt == 0) begin found = 1'b1; break; end
      tick();
    end
    check("v5_third_write_seen", 32'(found), 1);
    enable = 1'b0; base = n_ack;
    for (int i = 0; i < 50; i++) begin
      if (n_ack != base) break;
      tick();
    end
    check("v5_ack_while_disabled", n_ack - base, 1);
    sb = n_stb_cyc;
    repeat (10) tick();
    check("v5_no_stb_disabled", n_stb_cyc - sb, 0);
    enable = 1'b1;
    drain();
    check("v5_writes", n_obs - b, 6);
    check("v5_adr_resume", obs_adr[b+3], 32'hC);
    check("v5_adr_last", obs_adr[b+5], 32'h14);

    // V6: reset while waiting for ack; the ack landing in the reset cycle is ignored.
    do_reset();
    ack_delay = 0; ack_block = 1'b1;
    send(1, 32'h300); send(0, 32'h301);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (wshb_stb === 1'b1) begin found = 1'b1; break; end
      tick();
    end
    check("v6_stb_before_reset", 32'(found), 1);
    ack_block = 1'b0;
    do_reset();
    b = n_obs; er0 = n_err;
    send(0, 32'h310); send(0, 32'h311); send(1, 32'h320); send(0, 32'h321);
    drain();
    check("v6_writes", n_obs - b, 2);
    check("v6_adr0", obs_adr[b], 32'h0);
    check("v6_dat0", obs_dat[b], 32'h320);
    check("v6_adr1", obs_adr[b+1], 32'h4);
    check("v6_sof_err_count", n_err - er0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frame_writer.md
FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 Parameter HDISP, default 800, active pixels per line.
REQ-002 Parameter VDISP, default 480, active lines per frame.
REQ-003 Parameter FIFO_DEPTH_WIDTH, default 4, log2 of internal FIFO depth (16 entries).
REQ-004 clk  input  1  single clock for all logic; stream and Wishbone share it.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 pix_valid  input  1  input pixel word present.
REQ-007 pix_ready  output  1  block accepts pixel word this cycle.
REQ-008 pix_data  input  32  pixel word (RGB in low 24 bits, upper 8 bits written unchanged).
REQ-009 pix_sof  input  1  qualifies pix_data as first pixel of a frame (x=0,y=0).
REQ-010 enable  input  1  permits new Wishbone transfers.
REQ-011 wshb_cyc, wshb_stb, wshb_we  output  1 each  Wishbone classic master controls.
REQ-012 wshb_adr  output  32  byte address; wshb_sel output 4; wshb_cti output 3; wshb_bte output 2.
REQ-013 wshb_dat_ms  output  32  write data; wshb_ack  input  1  slave acknowledge.
REQ-014 frame_done  output  1  one-cycle pulse when the last pixel of a frame is acknowledged.
REQ-015 sof_err  output  1  one-cycle pulse when a SOF word is written while address counters are not at (0,0).

Function
REQ-016 Input handshake: word accepted on cycle where pix_valid && pix_ready; pix_ready = FIFO not full.
REQ-017 Accepted words (pix_sof, pix_data) stored in a 33-bit synchronous FIFO, 2**FIFO_DEPTH_WIDTH entries, first-word-fall-through.
REQ-018 Input synchronisation: after reset, accepted words with pix_sof=0 are discarded (not stored) until first word with pix_sof=1; pix_ready still follows REQ-016.
REQ-019 FSM states: IDLE, REQ, WAIT_ACK.
REQ-020 IDLE -> REQ when FIFO non-empty and enable=1; REQ lasts exactly 1 cycle, latches FIFO head into adr/data registers, pops FIFO, then -> WAIT_ACK.
REQ-021 WAIT_ACK: wshb_cyc=wshb_stb=1; adr, dat_ms held stable; on wshb_ack -> IDLE, or directly -> REQ if FIFO non-empty and enable=1.
REQ-022 wshb_cyc and wshb_stb are asserted only in WAIT_ACK; 0 in IDLE and REQ.
REQ-023 Constant outputs: wshb_we=1, wshb_sel=4'b1111, wshb_cti=0, wshb_bte=0.
REQ-024 Address counters x (0..HDISP-1), y (0..VDISP-1) on Wishbone side; wshb_adr = (x + y*HDISP)*4, zero-extended to 32 bits, computed at latch time.
REQ-025 Popped word with sof=1 forces x=y=0 for its own address; if counters were not (0,0), sof_err pulses in REQ cycle.
REQ-026 On each wshb_ack: x increments; at x=HDISP-1, x wraps to 0 and y increments; at (HDISP-1,VDISP-1), both wrap to 0 and frame_done pulses same cycle as the ack is registered (next cycle).
REQ-027 enable=0 never aborts a transfer in WAIT_ACK; it only blocks IDLE->REQ.
REQ-028 FIFO full and simultaneous push/pop: push accepted only when not full before the pop; count unchanged when both occur.
REQ-029 Throughput: one word per 2 cycles max with zero-wait-state slave (REQ + ack cycle).

Reset
REQ-030 rst_n=0 sampled on clk edge: FSM -> IDLE, FIFO emptied, x=y=0, sync flag cleared, wshb_cyc=wshb_stb=0, wshb_adr=0, wshb_dat_ms=0, pix_ready=0, frame_done=0, sof_err=0.
REQ-031 pix_ready rises first cycle after rst_n returns 1.
REQ-032 Reset during WAIT_ACK drops stb/cyc next edge; an ack arriving in the reset cycle is ignored.

Verification
V1 Reset released, 3 words sof=0 then sof=1 word 0xA5 -> first three dropped; one write, adr=0x0, dat=0xA5.
V2 HDISP=4, VDISP=2, full frame of 8 words, zero-wait ack -> adr 0x00..0x1C step 4, frame_done single pulse after 8th ack, stb gaps one cycle each.
V3 Slave delays ack 5 cycles, source streams continuously -> adr/dat stable while stb=1; pix_ready drops after 16 stored words; no word lost or duplicated.
V4 SOF injected at pixel 5 of line 1 (HDISP=4) -> sof_err pulses once; that word written to adr 0x0; following words 0x4, 0x8...
V5 enable=0 mid-frame while WAIT_ACK -> current transfer completes on ack, no stb until enable=1, then resumes at next address.
V6 rst_n=0 during WAIT_ACK -> stb=cyc=0 next cycle, pix_ready=0; after release, data before next SOF dropped.
